ecc_sec_encoder: RTL and testbench
==================================

ECC_SEC_ENCODER -- requirements
Module: ecc_sec_encoder

Interface
REQ-001 Parameter: none; all widths are fixed by package constants.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  in  1  upstream word valid.
REQ-005 in_ready  out  1  block can accept word this cycle.
REQ-006 in_data  in  32  data word d[31:0].
REQ-007 out_valid  out  1  codeword valid toward SEC corrector.
REQ-008 out_ready  in  1  corrector accepts codeword this cycle.
REQ-009 out_data  out  32  registered data bits.
REQ-010 out_check  out  8  registered check bits c[7:0].
REQ-011 word_cnt  out  16  count of codewords accepted downstream.
REQ-012 With ECC_ERR_INJECT_EN only: inj_req in 1 (arm injection), inj_bit in 6 (codeword bit index 0..39, 32..39 = c[0..7]), inj_pend out 1.

Function
REQ-013 c[k] SHALL be the XOR-reduce of (d AND CHK_MASK[k]); masks c0..c3 = 0x000000FF, 0x0000FF00, 0x00FF0000, 0xFF000000; c4..c7 = 0xAAAAAAAA, 0xCCCCCCCC, 0xF0F0F0F0, 0x69696969.
REQ-014 Two pipeline stages: S1 registers in_data; S2 registers data plus computed check; out_* driven only from S2 registers.
REQ-015 Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
REQ-016 S2 loads when S1 valid and (S2 empty or S2 transferring out); S1 loads when in transfer occurs.
REQ-017 in_ready = !s1_valid || s1_advances (combinational from out_ready; no combinational path from in_* to out_*).
REQ-018 Latency 2 cycles from input transfer to out_valid with out_ready held high; throughput 1 word/cycle sustained.
REQ-019 out_data/out_check SHALL remain stable while out_valid && !out_ready.
REQ-020 Words SHALL leave in acceptance order; none dropped or duplicated; maximum 2 words held.
REQ-021 word_cnt increments by 1 per output transfer, wraps 0xFFFF -> 0x0000.
REQ-022 Simultaneous in- and out-transfer with both stages full SHALL keep both full and advance one word.

Reset
REQ-023 On rst_n low: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_check=0, word_cnt=0, in_ready=1 after release, inj_pend=0.
REQ-024 Reset mid-stream SHALL discard all held words; no output transfer in the reset-deassertion cycle.

Configuration
REQ-025 Macro ECC_ERR_INJECT_EN: when defined, inj_req pulse sets inj_pend and latches inj_bit; next word loaded into S2 has that codeword bit inverted, and inj_pend clears on that load.
REQ-026 inj_req while inj_pend=1 SHALL overwrite inj_bit; inj_bit > 39 SHALL clear inj_pend with no flip.
REQ-027 Without ECC_ERR_INJECT_EN the injection ports and logic SHALL be absent and codewords always clean.

Structure
REQ-028 Shared package ecc_pkg SHALL hold DATA_W=32, CHK_W=8, CHK_MASK[0:7] array, and a codeword struct {data, check}.
REQ-029 Check generation SHALL be a sub-module ecc_chk_gen (pure combinational, 32 in, 8 out) shared with the corrector bench.

Verification
REQ-030 in_data 0x00000001, out_ready=1 -> out_check 0x81 two cycles later, word_cnt 1.
REQ-031 in_data 0xFFFFFFFF -> out_check 0x00; in_data 0x00000080 -> out_check 0x71.
REQ-032 Stream 4 words, out_ready=0 for 5 cycles -> in_ready drops after 2 accepted, out_* stable, then words 1..4 emitted in order.
REQ-033 Random data/ready for 10000 cycles -> every codeword matches reference mask model; word_cnt equals transfers mod 65536.
REQ-034 rst_n pulsed low with 2 words held -> out_valid 0 immediately, word_cnt 0, no stale word emitted afterward.
REQ-035 (ECC_ERR_INJECT_EN) inj_bit=35, data 0x00000001 -> out_check 0x89, next word clean, inj_pend 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared constants, codeword type and check/flip helpers for the SEC encoder and corrector.
// Optional error injection in the encoder is enabled with macro ECC_ERR_INJECT_EN.
package ecc_pkg;

   localparam int DATA_W = 32;
   localparam int CHK_W  = 8;
   localparam int CW_W   = DATA_W + CHK_W;

   localparam logic [5:0] CW_MAX_IDX = 6'd39;

   // Byte-lane parities c0..c3, then interleaved masks c4..c7
   localparam logic [DATA_W-1:0] CHK_MASK [0:CHK_W-1] = '{
      32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000,
      32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'h69696969
   };

   typedef struct packed {
      logic [CHK_W-1:0]  check;
      logic [DATA_W-1:0] data;
   } codeword_t;

   function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] d);
      logic [CHK_W-1:0] c;
      for (int k = 0; k < CHK_W; k++) begin
         c[k] = ^(d & CHK_MASK[k]);
      end
      return c;
   endfunction

   // Bit 32..39 of the flattened codeword are c[0..7]
   function automatic codeword_t flip_bit(input codeword_t cw, input logic [5:0] idx);
      logic [CW_W-1:0] one;
      one = {{(CW_W-1){1'b0}}, 1'b1};
      return cw ^ (one << idx);
   endfunction

endpackage

// File: rtl/ecc_chk_gen.sv
// Combinational check-bit generator, shared between the encoder and the corrector bench.
module ecc_chk_gen
   import ecc_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   output logic [CHK_W-1:0]  check
);

   // Each check bit is the parity of its masked data subset
   always_comb begin
      check = calc_check(data);
   end

endmodule

// File: rtl/ecc_sec_encoder.sv
// Two-stage valid/ready SEC encoder: S1 holds the raw word, S2 holds the registered codeword.
// Define ECC_ERR_INJECT_EN to add the single-bit error injection ports and logic.
module ecc_sec_encoder
   import ecc_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
`ifdef ECC_ERR_INJECT_EN
   input  logic              inj_req,
   input  logic [5:0]        inj_bit,
   output logic              inj_pend,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CHK_W-1:0]  out_check,
   output logic [15:0]       word_cnt
);

   logic              s1_valid_r;
   logic [DATA_W-1:0] s1_data_r;
   logic              s2_valid_r;
   codeword_t         s2_cw_r;
   logic [15:0]       word_cnt_r;

   logic              in_fire_s;
   logic              out_fire_s;
   logic              s2_load_s;
   logic [CHK_W-1:0]  chk_s;
   codeword_t         cw_base_s;
   codeword_t         cw_s;

   ecc_chk_gen u_chk_gen (
      .data  (s1_data_r),
      .check (chk_s)
   );

   // Handshake decode; in_ready depends on out_ready only through S2 draining
   always_comb begin
      out_fire_s = s2_valid_r && out_ready;
      s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
      in_ready   = !s1_valid_r || s2_load_s;
      in_fire_s  = in_valid && in_ready;
   end

   // Assemble the clean codeword from S1
   always_comb begin
      cw_base_s.check = chk_s;
      cw_base_s.data  = s1_data_r;
   end

`ifdef ECC_ERR_INJECT_EN
   logic       inj_pend_r;
   logic [5:0] inj_bit_r;

   // A new request re-arms (or disarms when out of range); the next S2 load consumes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_pend_r <= 1'b0;
         inj_bit_r  <= 6'd0;
      end else if (inj_req) begin
         inj_bit_r  <= inj_bit;
         inj_pend_r <= (inj_bit <= CW_MAX_IDX);
      end else if (s2_load_s) begin
         inj_pend_r <= 1'b0;
      end
   end

   // Apply the armed flip to the word entering S2
   always_comb begin
      if (inj_pend_r) begin
         cw_s = flip_bit(cw_base_s, inj_bit_r);
      end else begin
         cw_s = cw_base_s;
      end
   end

   assign inj_pend = inj_pend_r;
`else
   // Clean codeword path
   always_comb begin
      cw_s = cw_base_s;
   end
`endif

   // S1: raw data register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= {DATA_W{1'b0}};
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         s1_data_r  <= in_data;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // S2: codeword register; holds steady while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_r <= 1'b0;
         s2_cw_r    <= {CW_W{1'b0}};
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         s2_cw_r    <= cw_s;
      end else if (out_fire_s) begin
         s2_valid_r <= 1'b0;
      end
   end

   // Downstream transfer counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_r <= 16'd0;
      end else if (out_fire_s) begin
         word_cnt_r <= word_cnt_r + 16'd1;
      end
   end

   assign out_valid = s2_valid_r;
   assign out_data  = s2_cw_r.data;
   assign out_check = s2_cw_r.check;
   assign word_cnt  = word_cnt_r;

endmodule

// File: tb/tb_ecc_sec_encoder.sv
// Bench for ecc_sec_encoder: vector table, hand sequences and a random run against a queue model.
module tb_ecc_sec_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [7:0]  out_check;
   logic [15:0] word_cnt;
`ifdef ECC_ERR_INJECT_EN
   logic        inj_req;
   logic [5:0]  inj_bit;
   logic        inj_pend;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ecc_sec_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ECC_ERR_INJECT_EN
      .inj_req   (inj_req),
      .inj_bit   (inj_bit),
      .inj_pend  (inj_pend),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_check (out_check),
      .word_cnt  (word_cnt)
   );

   localparam logic [31:0] MASKS [0:7] = '{
      32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFF000000,
      32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'h69696969
   };

   function automatic logic [7:0] ref_check(input logic [31:0] d);
      logic [7:0] c;
      for (int k = 0; k < 8; k++) begin
         c[k] = (($countones(d & MASKS[k]) % 2) == 1);
      end
      return c;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: ordered queue of expected codewords, at most two in flight
   logic [39:0] model_q [$];
   logic [15:0] cnt_m     = 16'd0;
   logic        stall_p   = 1'b0;
   logic [39:0] held_p    = 40'd0;
   logic [39:0] pend_flip = 40'd0;

   always @(negedge clk) begin
      if (!rst_n) begin
         model_q.delete();
         cnt_m   = 16'd0;
         stall_p = 1'b0;
         check("reset_out_valid", out_valid, 1'b0);
      end else begin
         check("word_cnt", word_cnt, cnt_m);
         if (model_q.size() == 0) check("empty_no_valid", out_valid, 1'b0);
         if (stall_p) check("stall_stable", {out_valid, out_check, out_data}, {1'b1, held_p});
         if (out_valid && out_ready && model_q.size() > 0) begin
            check("codeword", {out_check, out_data}, model_q[0]);
            void'(model_q.pop_front());
            cnt_m = cnt_m + 16'd1;
         end
         check("in_ready", in_ready, model_q.size() < 2);
         if (in_valid && in_ready) begin
            model_q.push_back({ref_check(in_data), in_data} ^ pend_flip);
            pend_flip = 40'd0;
         end
         stall_p = out_valid && !out_ready;
         held_p  = {out_check, out_data};
      end
   end

   typedef struct {
      logic [31:0] d;
      logic [7:0]  chk;
   } vec_t;

   vec_t        tab [6];
   logic [31:0] got [4];
   int          got_n;
   int          idx;
   int          acc;
   int          waited;
   int          guard;
   logic        fire;

   initial begin
      tab[0] = '{32'h00000001, 8'h81};
      tab[1] = '{32'hFFFFFFFF, 8'h00};
      tab[2] = '{32'h00000080, 8'h71};
      tab[3] = '{32'h00000100, 8'h82};
      tab[4] = '{32'h80000000, 8'h78};
      tab[5] = '{32'h00000003, 8'h90};

      rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
`ifdef ECC_ERR_INJECT_EN
      inj_req = 1'b0; inj_bit = 6'd0;
`endif
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_check", out_check, 8'd0);
      check("rst_word_cnt", word_cnt, 16'd0);
      rst_n = 1'b1;
      #1 check("rst_in_ready", in_ready, 1'b1);

      // Two-cycle latency for a single word
      out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h00000001;
      @(posedge clk); #2 in_valid = 1'b0;
      #1 check("lat1_out_valid", out_valid, 1'b0);
      @(posedge clk); #3;
      check("lat2_out_valid", out_valid, 1'b1);
      check("lat2_out_check", out_check, 8'h81);
      @(posedge clk); #3;
      check("lat_word_cnt", word_cnt, 16'd1);
      check("lat_drained", out_valid, 1'b0);

      // Table of known codewords
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_data = tab[i].d;
         @(posedge clk); #2 in_valid = 1'b0;
         waited = 0;
         while (!out_valid && waited < 8) begin
            @(posedge clk); #2;
            waited++;
         end
         check($sformatf("tab%0d_valid", i), out_valid, 1'b1);
         check($sformatf("tab%0d_check", i), out_check, tab[i].chk);
         check($sformatf("tab%0d_data", i), out_data, tab[i].d);
         @(posedge clk); #2;
      end

      // Backpressure: only two words fit, output held, then order preserved
      out_ready = 1'b0; acc = 0; idx = 1;
      in_valid = 1'b1; in_data = 32'd1;
      for (int c = 0; c < 5; c++) begin
         fire = in_ready;
         @(posedge clk); #2;
         if (fire) begin
            acc++;
            idx++;
         end
         in_data = idx;
      end
      #1;
      check("stall_accepted", acc, 2);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_data", out_data, 32'd1);
      check("stall_out_check", out_check, ref_check(32'd1));
      out_ready = 1'b1; got_n = 0;
      for (int c = 0; c < 20 && got_n < 4; c++) begin
         in_valid = (idx <= 4); in_data = idx;
         #1;
         fire = in_valid && in_ready;
         if (out_valid) begin
            got[got_n] = out_data;
            got_n++;
         end
         @(posedge clk); #1;
         if (fire) idx++;
      end
      in_valid = 1'b0;
      check("order_count", got_n, 4);
      for (int k = 0; k < 4; k++) check($sformatf("order_%0d", k), got[k], k + 1);

      // Random traffic, checked by the model
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk); #2;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       in_data = 32'd0;
            1:       in_data = 32'hFFFFFFFF;
            default: in_data = $urandom();
         endcase
      end
      @(posedge clk); #2 in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #2 check("rand_drained", out_valid, 1'b0);

      // Sustained streaming up to and past the counter wrap
      in_valid = 1'b1; out_ready = 1'b1; guard = 0;
      while (word_cnt != 16'hFFFF && guard < 70000) begin
         in_data = $urandom();
         @(posedge clk); #2;
         guard++;
      end
      check("reach_ffff", word_cnt, 16'hFFFF);
      in_data = $urandom();
      @(posedge clk); #2 check("wrap_0000", word_cnt, 16'h0000);
      @(posedge clk); #2 check("wrap_0001", word_cnt, 16'h0001);

      // Reset with two words held
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 in_valid = 1'b0;
      #1 check("held_in_ready", in_ready, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_word_cnt", word_cnt, 16'd0);
      check("midrst_in_ready", in_ready, 1'b1);
      @(posedge clk); #2 rst_n = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2 check($sformatf("no_stale_%0d", c), out_valid, 1'b0);
      end

`ifdef ECC_ERR_INJECT_EN
      // Flip c[3] of the next word only
      inj_bit = 6'd35; inj_req = 1'b1;
      @(posedge clk); #2 inj_req = 1'b0;
      #1 check("inj_armed", inj_pend, 1'b1);
      pend_flip = 40'd1 << 35;
      in_valid = 1'b1; in_data = 32'h00000001;
      @(posedge clk); #2 in_data = 32'h00000002;
      @(posedge clk); #2 in_valid = 1'b0;
      check("inj_pend_clear", inj_pend, 1'b0);
      check("inj_check", out_check, 8'h89);
      @(posedge clk); #2 check("inj_next_clean", out_check, ref_check(32'd2));
      // Re-arm overwrites the bit index
      inj_bit = 6'd35; inj_req = 1'b1;
      @(posedge clk); #2 inj_bit = 6'd32;
      @(posedge clk); #2 inj_req = 1'b0;
      pend_flip = 40'd1 << 32;
      in_valid = 1'b1; in_data = 32'h00000001;
      @(posedge clk); #2 in_valid = 1'b0;
      @(posedge clk); #2 check("inj_overwrite", out_check, 8'h80);
      // Out-of-range index disarms
      inj_bit = 6'd3; inj_req = 1'b1;
      @(posedge clk); #2 inj_bit = 6'd45;
      @(posedge clk); #2 inj_req = 1'b0;
      #1 check("inj_disarm", inj_pend, 1'b0);
      in_valid = 1'b1; in_data = 32'h00000001;
      @(posedge clk); #2 in_valid = 1'b0;
      @(posedge clk); #2 check("inj_none", out_check, 8'h81);
      @(posedge clk); #2;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
